// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall controller.
//   state_t    : controller FSM state encoding
//   ctl_t      : bundle of stall/flush enables driven by the controller
//   REG_AW_DEF : default register-address width
package pipe_ctrl_pkg;

  localparam int unsigned REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DIV   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic stall_w;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
  } ctl_t;

  // Exception/eret: clear every stage behind fetch, hold nothing.
  localparam ctl_t CTL_FLUSH_ALL = '{stall_f: 1'b0, stall_d: 1'b0, stall_e: 1'b0,
                                     stall_m: 1'b0, stall_w: 1'b0, flush_d: 1'b1,
                                     flush_e: 1'b1, flush_m: 1'b1, flush_w: 1'b1};

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational data-hazard detection for the decode stage.
//   rs_d, rt_d              : decode-stage source registers
//   branch_d                : decode holds a branch/jr (operands needed in decode)
//   rt_e, writereg_e,
//   memtoreg_e, regwrite_e  : execute-stage destination info
//   writereg_m, memtoreg_m  : memory-stage destination info
//   lwstall, branchstall    : hazard flags (register 0 never hazards)
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              branch_d,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] writereg_e,
  input  logic              memtoreg_e,
  input  logic              regwrite_e,
  input  logic [REG_AW-1:0] writereg_m,
  input  logic              memtoreg_m,
  output logic              lwstall,
  output logic              branchstall
);

  logic e_hit;
  logic m_hit;

  // Load in execute feeding a decode-stage operand.
  assign lwstall = memtoreg_e && (rt_e != '0) && ((rt_e == rs_d) || (rt_e == rt_d));

  // Branch operands resolved in decode cannot take an ALU result from execute
  // or a load result still in memory.
  assign e_hit = regwrite_e && (writereg_e != '0) &&
                 ((writereg_e == rs_d) || (writereg_e == rt_d));
  assign m_hit = memtoreg_m && (writereg_m != '0) &&
                 ((writereg_m == rs_d) || (writereg_m == rt_d));

  assign branchstall = branch_d && (e_hit || m_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller for a 5-stage pipeline with a multi-cycle
// divider and exception flush.
//   clk, rst                : clock, synchronous active-high reset
//   i_stall, d_stall        : instruction/data bus busy
//   rs_d, rt_d, branch_d    : decode-stage operands / branch flag
//   rt_e, writereg_e,
//   memtoreg_e, regwrite_e  : execute-stage info
//   writereg_m, memtoreg_m  : memory-stage info
//   div_start_e, div_ready  : divider issue / result valid
//   flush_except            : exception or eret taken in memory stage
//   stall_f..stall_w        : pipeline-register hold enables (combinational)
//   flush_d..flush_w        : pipeline-register clears (combinational)
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall,
  input  logic              d_stall,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              branch_d,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] writereg_e,
  input  logic              memtoreg_e,
  input  logic              regwrite_e,
  input  logic [REG_AW-1:0] writereg_m,
  input  logic              memtoreg_m,
  input  logic              div_start_e,
  input  logic              div_ready,
  input  logic              flush_except,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              stall_w,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              flush_w
);

  state_t state;
  state_t state_nxt;
  state_t run_nxt;
  ctl_t   ctl;
  ctl_t   run_ctl;
  logic   lwstall;
  logic   branchstall;
  logic   mem_busy;

  assign mem_busy = i_stall || d_stall;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .rs_d        (rs_d),
    .rt_d        (rt_d),
    .branch_d    (branch_d),
    .rt_e        (rt_e),
    .writereg_e  (writereg_e),
    .memtoreg_e  (memtoreg_e),
    .regwrite_e  (regwrite_e),
    .writereg_m  (writereg_m),
    .memtoreg_m  (memtoreg_m),
    .lwstall     (lwstall),
    .branchstall (branchstall)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Normal-run decision; also reused when the divider completes.
  always_comb begin
    run_ctl = '0;
    run_nxt = RUN;
    if (flush_except) begin
      run_ctl = CTL_FLUSH_ALL;
      run_nxt = i_stall ? DRAIN : RUN;
    end else if (mem_busy) begin
      run_ctl.stall_f = 1'b1;
      run_ctl.stall_d = 1'b1;
      run_ctl.stall_e = 1'b1;
      run_ctl.stall_m = 1'b1;
      run_ctl.stall_w = 1'b1;
    end else if (div_start_e) begin
      // Hold the div in execute and bubble memory until the result is valid.
      run_ctl.stall_f = 1'b1;
      run_ctl.stall_d = 1'b1;
      run_ctl.stall_e = 1'b1;
      run_ctl.flush_m = 1'b1;
      run_nxt         = DIV;
    end else if (lwstall || branchstall) begin
      run_ctl.stall_f = 1'b1;
      run_ctl.stall_d = 1'b1;
      run_ctl.flush_e = 1'b1;
    end
  end

  // Next-state and output selection.
  always_comb begin
    state_nxt = state;
    ctl       = '0;
    case (state)
      DIV: begin
        if (flush_except || div_ready) begin
          ctl       = run_ctl;
          state_nxt = run_nxt;
        end else begin
          ctl.stall_f = 1'b1;
          ctl.stall_d = 1'b1;
          ctl.stall_e = 1'b1;
          // A busy bus freezes memory/writeback instead of bubbling memory.
          ctl.stall_m = mem_busy;
          ctl.stall_w = mem_busy;
          ctl.flush_m = !mem_busy;
        end
      end
      DRAIN: begin
        // The fetch in flight at the exception returns a stale instruction;
        // keep decode cleared until it lands, then drop it.
        if (flush_except) ctl = CTL_FLUSH_ALL;
        ctl.flush_d = 1'b1;
        ctl.stall_f = i_stall;
        state_nxt   = i_stall ? DRAIN : RUN;
      end
      default: begin
        ctl       = run_ctl;
        state_nxt = run_nxt;
      end
    endcase
    if (rst) begin
      ctl       = '0;
      state_nxt = RUN;
    end
  end

  assign stall_f = ctl.stall_f;
  assign stall_d = ctl.stall_d;
  assign stall_e = ctl.stall_e;
  assign stall_m = ctl.stall_m;
  assign stall_w = ctl.stall_w;
  assign flush_d = ctl.flush_d;
  assign flush_e = ctl.flush_e;
  assign flush_m = ctl.flush_m;
  assign flush_w = ctl.flush_w;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
// Expected vectors are {stall_f,stall_d,stall_e,stall_m,stall_w,flush_d,flush_e,flush_m,flush_w}.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_stall, d_stall;
  logic [AW-1:0] rs_d, rt_d, rt_e, writereg_e, writereg_m;
  logic          branch_d, memtoreg_e, regwrite_e, memtoreg_m;
  logic          div_start_e, div_ready, flush_except;
  logic          stall_f, stall_d, stall_e, stall_m, stall_w;
  logic          flush_d, flush_e, flush_m, flush_w;

  int checks = 0;
  int errors = 0;

  localparam logic [8:0] NONE   = 9'b00000_0000;
  localparam logic [8:0] HAZ    = 9'b11000_0100;
  localparam logic [8:0] BUSY   = 9'b11111_0000;
  localparam logic [8:0] DIVW   = 9'b11100_0010;
  localparam logic [8:0] FLALL  = 9'b00000_1111;
  localparam logic [8:0] DRHOLD = 9'b10000_1000;
  localparam logic [8:0] DRLAST = 9'b00000_1000;

  pipe_ctrl #(.REG_AW(AW)) dut (
    .clk(clk), .rst(rst), .i_stall(i_stall), .d_stall(d_stall),
    .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d),
    .rt_e(rt_e), .writereg_e(writereg_e), .memtoreg_e(memtoreg_e), .regwrite_e(regwrite_e),
    .writereg_m(writereg_m), .memtoreg_m(memtoreg_m),
    .div_start_e(div_start_e), .div_ready(div_ready), .flush_except(flush_except),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m), .stall_w(stall_w),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w)
  );

  always #5 clk = ~clk;

  task automatic idle();
    i_stall = 0; d_stall = 0; rs_d = '0; rt_d = '0; branch_d = 0;
    rt_e = '0; writereg_e = '0; memtoreg_e = 0; regwrite_e = 0;
    writereg_m = '0; memtoreg_m = 0; div_start_e = 0; div_ready = 0; flush_except = 0;
  endtask

  // Advance to just after the next rising edge; inputs are then applied.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    #2;
    obs = {stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e, flush_m, flush_w};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input state_t exp);
    checks++;
    assert (dut.state === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, dut.state, exp);
    end
  endtask

  initial begin
    idle();
    rst = 1;
    next_cycle();
    // Reset masks a live hazard.
    memtoreg_e = 1; rt_e = 5'd5; rs_d = 5'd5; flush_except = 1; d_stall = 1;
    chk("reset_outputs", NONE);
    chk_state("reset_state", RUN);

    next_cycle(); rst = 0; idle();
    chk("idle", NONE);

    // Load-use hazard, one cycle.
    next_cycle(); memtoreg_e = 1; rt_e = 5'd5; rs_d = 5'd5;
    chk("lwstall_rs", HAZ);
    next_cycle(); idle();
    chk("lwstall_gone", NONE);
    next_cycle(); memtoreg_e = 1; rt_e = 5'd9; rt_d = 5'd9; rs_d = 5'd1;
    chk("lwstall_rt", HAZ);
    next_cycle(); idle(); memtoreg_e = 1; rt_e = '0; rs_d = '0;
    chk("lwstall_r0", NONE);

    // Branch hazards.
    next_cycle(); idle(); branch_d = 1; regwrite_e = 1; writereg_e = 5'd3; rt_d = 5'd3;
    chk("branch_e", HAZ);
    next_cycle(); idle(); branch_d = 1; memtoreg_m = 1; writereg_m = 5'd7; rs_d = 5'd7;
    chk("branch_m", HAZ);
    next_cycle(); idle(); branch_d = 1; regwrite_e = 1; writereg_e = '0; memtoreg_m = 1;
    chk("branch_r0", NONE);
    next_cycle(); idle(); branch_d = 0; regwrite_e = 1; writereg_e = 5'd3; rt_d = 5'd3;
    chk("no_branch_no_stall", NONE);

    // Data bus busy for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      next_cycle(); idle(); d_stall = 1;
      chk("d_stall", BUSY);
    end
    next_cycle(); idle(); i_stall = 1;
    chk("i_stall", BUSY);

    // Bus busy outranks div start: no DIV entry.
    next_cycle(); idle(); d_stall = 1; div_start_e = 1;
    chk("busy_over_div", BUSY);
    next_cycle(); idle();
    chk("busy_over_div_after", NONE);

    // Divide: 34 stall cycles, then RUN outputs in the div_ready cycle.
    next_cycle(); idle(); div_start_e = 1;
    chk("div_start", DIVW);
    for (int i = 1; i < 34; i++) begin
      next_cycle(); idle();
      chk("div_wait", DIVW);
    end
    next_cycle(); idle(); div_ready = 1;
    chk("div_ready", NONE);
    next_cycle(); idle();
    chk("after_div", NONE);
    chk_state("after_div_state", RUN);

    // Bus busy inside DIV, then reset mid-DIV.
    next_cycle(); idle(); div_start_e = 1;
    chk("div2_start", DIVW);
    next_cycle(); idle(); d_stall = 1;
    chk("div_busy", BUSY);
    next_cycle(); idle();
    chk("div_unbusy", DIVW);
    next_cycle(); idle(); rst = 1;
    chk("div_rst", NONE);
    next_cycle(); rst = 0;
    chk("after_rst_div", NONE);
    chk_state("after_rst_div_state", RUN);

    // Exception inside DIV returns to RUN.
    next_cycle(); idle(); div_start_e = 1;
    chk("div3_start", DIVW);
    next_cycle(); idle(); flush_except = 1;
    chk("div_except", FLALL);
    next_cycle(); idle();
    chk("div_except_after", NONE);
    chk_state("div_except_state", RUN);

    // Exception with coincident div start: div ignored.
    next_cycle(); idle(); flush_except = 1; div_start_e = 1;
    chk("except_div", FLALL);
    next_cycle(); idle();
    chk("except_div_after", NONE);
    chk_state("except_div_state", RUN);

    // Exception during a fetch: drain for the in-flight instruction.
    next_cycle(); idle(); flush_except = 1; i_stall = 1;
    chk("drain_enter", FLALL);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); idle(); i_stall = 1;
      chk("drain_hold", DRHOLD);
    end
    next_cycle(); idle();
    chk("drain_last", DRLAST);
    next_cycle(); idle();
    chk("drain_done", NONE);
    chk_state("drain_done_state", RUN);

    // Reset during DRAIN.
    next_cycle(); idle(); flush_except = 1; i_stall = 1;
    chk("drain2_enter", FLALL);
    next_cycle(); idle(); i_stall = 1; rst = 1;
    chk("drain_rst", NONE);
    next_cycle(); rst = 0; idle(); i_stall = 1;
    chk("after_rst_drain", BUSY);

    next_cycle(); idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
